// File: rtl/sram_1r1w_sp_emul_if.sv
// Request/response bundle of the 1R1W memory front end.
// The master is the requester; the slave is the emulation block.
interface sram_1r1w_sp_emul_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int MASK_W = DATA_W / 8
);
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [MASK_W-1:0] w_mask;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              r_data_valid;
  logic [DATA_W-1:0] r_data;
  logic              wbuf_empty;

  modport master (
    output w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
    input  w_ready, r_ready, r_data_valid, r_data, wbuf_empty
  );

  modport slave (
    input  w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
    output w_ready, r_ready, r_data_valid, r_data, wbuf_empty
  );
endinterface

// File: rtl/sram_1r1w_sp_emul.sv
// 1R1W memory emulated on a single-port macro: reads own the port, writes are
// buffered and drained on read-idle cycles, reads forward bytes from the buffer.
module sram_1r1w_sp_emul #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int MASK_W     = DATA_W / 8,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_1r1w_sp_emul_if.slave  bus,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WBUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WBUF_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [ADDR_W-1:0] buf_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] buf_data_q [WBUF_DEPTH];
  logic [MASK_W-1:0] buf_mask_q [WBUF_DEPTH];

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MASK_W-1:0] fwd_mask_q, fwd_mask_d, merge_mask_s;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d, merge_data_s;
  logic              r_data_valid_q, r_data_valid_d;
  logic [DATA_W-1:0] r_data_q, r_data_d, r_merged_s;
  logic              full_s, accept_s, rd_issue_s, drain_s, hit_s, take_s;
  logic [PTR_W-1:0]  idx_s;

  // Port arbitration: a read wins unless the buffer is full, then the head drains.
  always_comb begin
    full_s      = (cnt_q == CNT_FULL);
    accept_s    = bus.w_valid && !full_s;
    rd_issue_s  = bus.r_valid && !full_s;
    drain_s     = !rd_issue_s && (cnt_q != {CNT_W{1'b0}});
    mem_ce      = rd_issue_s || drain_s;
    mem_we      = drain_s;
    mem_addr    = rd_issue_s ? bus.r_addr : buf_addr_q[rd_ptr_q];
    mem_wdata   = buf_data_q[rd_ptr_q];
    mem_wmask   = {DATA_W{1'b0}};
    for (int b = 0; b < MASK_W; b++) begin
      mem_wmask[8*b +: 8] = {8{buf_mask_q[rd_ptr_q][b]}};
    end
    bus.w_ready    = !full_s;
    bus.r_ready    = rd_issue_s;
    bus.wbuf_empty = (cnt_q == {CNT_W{1'b0}});
    wr_ptr_d    = accept_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = drain_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d       = cnt_q + CNT_W'(accept_s) - CNT_W'(drain_s);
  end

  // Forward merge: walk valid entries oldest to youngest so the youngest byte wins.
  always_comb begin
    merge_mask_s = {MASK_W{1'b0}};
    merge_data_s = {DATA_W{1'b0}};
    idx_s        = {PTR_W{1'b0}};
    hit_s        = 1'b0;
    take_s       = 1'b0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      idx_s = PTR_W'((int'(rd_ptr_q) + k) % WBUF_DEPTH);
      hit_s = (k < int'(cnt_q)) && (buf_addr_q[idx_s] == bus.r_addr);
      for (int b = 0; b < MASK_W; b++) begin
        take_s                  = hit_s && buf_mask_q[idx_s][b];
        merge_mask_s[b]         = merge_mask_s[b] | take_s;
        merge_data_s[8*b +: 8]  = take_s ? buf_data_q[idx_s][8*b +: 8]
                                         : merge_data_s[8*b +: 8];
      end
    end
    fwd_mask_d     = rd_issue_s ? merge_mask_s : fwd_mask_q;
    fwd_data_d     = rd_issue_s ? merge_data_s : fwd_data_q;
    r_data_valid_d = rd_issue_s;
  end

  // Read return: forwarded bytes override the macro; hold the last word otherwise.
  always_comb begin
    r_merged_s = {DATA_W{1'b0}};
    for (int b = 0; b < MASK_W; b++) begin
      r_merged_s[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : mem_rdata[8*b +: 8];
    end
    r_data_d         = r_data_valid_q ? r_merged_s : r_data_q;
    bus.r_data       = r_data_d;
    bus.r_data_valid = r_data_valid_q;
  end

  // Control state: occupancy, pointers, forward capture and read-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= {CNT_W{1'b0}};
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      fwd_mask_q     <= {MASK_W{1'b0}};
      fwd_data_q     <= {DATA_W{1'b0}};
      r_data_valid_q <= 1'b0;
      r_data_q       <= {DATA_W{1'b0}};
    end else begin
      cnt_q          <= cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fwd_mask_q     <= fwd_mask_d;
      fwd_data_q     <= fwd_data_d;
      r_data_valid_q <= r_data_valid_d;
      r_data_q       <= r_data_d;
    end
  end

  // Write buffer storage: capture accepted writes at the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        buf_addr_q[i] <= {ADDR_W{1'b0}};
        buf_data_q[i] <= {DATA_W{1'b0}};
        buf_mask_q[i] <= {MASK_W{1'b0}};
      end
    end else if (accept_s) begin
      buf_addr_q[wr_ptr_q] <= bus.w_addr;
      buf_data_q[wr_ptr_q] <= bus.w_data;
      buf_mask_q[wr_ptr_q] <= bus.w_mask;
    end
  end

endmodule

// File: tb/tb_sram_1r1w_sp_emul.sv
// Directed bench: a 2-entry instance on a behavioural macro, plus a 4-entry
// instance used where two pending writes to one address must be forwarded.
module tb_sram_1r1w_sp_emul;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_1r1w_sp_emul_if #(.DATA_W(DW), .ADDR_W(AW), .MASK_W(MW)) ifc ();
  sram_1r1w_sp_emul_if #(.DATA_W(DW), .ADDR_W(AW), .MASK_W(MW)) ifc4 ();

  logic          mem_ce, mem_we, mem_ce4, mem_we4;
  logic [AW-1:0] mem_addr, mem_addr4;
  logic [DW-1:0] mem_wmask, mem_wdata, mem_rdata, mem_wmask4, mem_wdata4;
  logic [DW-1:0] mem_model [1024];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            we_cnt   = 0;
  int            we_base;

  sram_1r1w_sp_emul #(.DATA_W(DW), .DEPTH(1024), .WBUF_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  sram_1r1w_sp_emul #(.DATA_W(DW), .DEPTH(1024), .WBUF_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4),
    .mem_ce(mem_ce4), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_wmask(mem_wmask4), .mem_wdata(mem_wdata4), .mem_rdata(32'h5555_5555)
  );

  // Behavioural single-port macro for the 2-entry instance.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        mem_model[mem_addr] <= (mem_model[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        we_cnt <= we_cnt + 1;
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle on the 2-entry instance: drive after the falling edge, settle 1 time unit.
  task automatic cyc(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [MW-1:0] wm, input logic rv, input logic [AW-1:0] ra);
    @(negedge clk);
    ifc.w_valid = wv; ifc.w_addr = wa; ifc.w_data = wd; ifc.w_mask = wm;
    ifc.r_valid = rv; ifc.r_addr = ra;
    #1;
  endtask

  task automatic cyc4(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [MW-1:0] wm, input logic rv, input logic [AW-1:0] ra);
    @(negedge clk);
    ifc4.w_valid = wv; ifc4.w_addr = wa; ifc4.w_data = wd; ifc4.w_mask = wm;
    ifc4.r_valid = rv; ifc4.r_addr = ra;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    mem_model[10'h10] = 32'hAAAA_AAAA;
    mem_model[10'h30] = 32'h1234_5678;
    mem_model[10'h31] = 32'h9ABC_DEF0;
    mem_model[10'h07] = 32'h7777_7777;
    mem_rdata = '0;
    ifc.w_valid = 1'b0; ifc.w_addr = '0; ifc.w_data = '0; ifc.w_mask = '0;
    ifc.r_valid = 1'b0; ifc.r_addr = '0;
    ifc4.w_valid = 1'b0; ifc4.w_addr = '0; ifc4.w_data = '0; ifc4.w_mask = '0;
    ifc4.r_valid = 1'b0; ifc4.r_addr = '0;

    // Reset values
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("rst_w_ready", ifc.w_ready, 1'b1);
    check_eq("rst_wbuf_empty", ifc.wbuf_empty, 1'b1);
    check_eq("rst_rdv", ifc.r_data_valid, 1'b0);
    check_eq("rst_r_data", ifc.r_data, 32'h0);
    check_eq("rst_mem_ce", mem_ce, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Forwarding merges buffered bytes over macro data
    cyc(1'b1, 10'h10, 32'h1122_3344, 4'b0101, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h10);
    check_eq("fwd_r_ready", ifc.r_ready, 1'b1);
    check_eq("fwd_rd_we", mem_we, 1'b0);
    check_eq("fwd_rd_addr", mem_addr, 10'h10);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("fwd_rdv", ifc.r_data_valid, 1'b1);
    check_eq("fwd_r_data", ifc.r_data, 32'hAA22_AA44);
    check_eq("fwd_drain_we", mem_we, 1'b1);
    check_eq("fwd_drain_mask", mem_wmask, 32'h00FF_00FF);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("fwd_empty", ifc.wbuf_empty, 1'b1);
    check_eq("fwd_hold_rdv", ifc.r_data_valid, 1'b0);
    check_eq("fwd_hold_data", ifc.r_data, 32'hAA22_AA44);
    check_eq("fwd_macro", mem_model[10'h10], 32'hAA22_AA44);

    // Youngest pending write wins (4-entry instance, macro reads 0x55555555)
    cyc4(1'b1, 10'h5, 32'h0000_00FF, 4'b0001, 1'b1, 10'h7);
    cyc4(1'b1, 10'h5, 32'h0000_00EE, 4'b0001, 1'b1, 10'h7);
    cyc4(1'b0, '0, '0, '0, 1'b1, 10'h5);
    check_eq("yw_r_ready", ifc4.r_ready, 1'b1);
    cyc4(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("yw_r_data", ifc4.r_data, 32'h5555_55EE);
    check_eq("yw_drain_we", mem_we4, 1'b1);
    check_eq("yw_drain_addr", mem_addr4, 10'h5);
    check_eq("yw_drain_data", mem_wdata4, 32'h0000_00FF);
    check_eq("yw_drain_mask", mem_wmask4, 32'h0000_00FF);
    cyc4(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("yw_drain2_data", mem_wdata4, 32'h0000_00EE);
    cyc4(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("yw_empty", ifc4.wbuf_empty, 1'b1);

    // Full buffer stalls the read for one cycle while the head drains
    cyc(1'b1, 10'h40, 32'hCAFE_F00D, 4'hF, 1'b1, 10'h30);
    check_eq("full_c1_r_ready", ifc.r_ready, 1'b1);
    cyc(1'b1, 10'h41, 32'h0BAD_BEEF, 4'hF, 1'b1, 10'h31);
    check_eq("full_c2_r_ready", ifc.r_ready, 1'b1);
    check_eq("full_c2_r_data", ifc.r_data, 32'h1234_5678);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h40);
    check_eq("full_w_ready", ifc.w_ready, 1'b0);
    check_eq("full_r_ready", ifc.r_ready, 1'b0);
    check_eq("full_drain_we", mem_we, 1'b1);
    check_eq("full_drain_addr", mem_addr, 10'h40);
    check_eq("full_c3_r_data", ifc.r_data, 32'h9ABC_DEF0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h40);
    check_eq("full_rec_w_ready", ifc.w_ready, 1'b1);
    check_eq("full_rec_r_ready", ifc.r_ready, 1'b1);
    check_eq("full_rec_we", mem_we, 1'b0);
    check_eq("full_rec_rdv", ifc.r_data_valid, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h41);
    check_eq("full_rd40", ifc.r_data, 32'hCAFE_F00D);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("full_rd41", ifc.r_data, 32'h0BAD_BEEF);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("full_empty", ifc.wbuf_empty, 1'b1);

    // Same-cycle read and write: read sees the old word
    cyc(1'b1, 10'h20, 32'h5A5A_5A5A, 4'hF, 1'b1, 10'h20);
    cyc(1'b0, '0, '0, '0, 1'b1, 10'h20);
    check_eq("rbw_old", ifc.r_data, 32'h0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("rbw_new", ifc.r_data, 32'h5A5A_5A5A);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);

    // Drain to macro with replicated masks
    cyc(1'b1, 10'h50, 32'h0102_0304, 4'b0011, 1'b0, '0);
    we_base = we_cnt;
    check_eq("drn_idle_ce", mem_ce, 1'b0);
    cyc(1'b1, 10'h51, 32'hA0B0_C0D0, 4'b1000, 1'b0, '0);
    check_eq("drn1_addr", mem_addr, 10'h50);
    check_eq("drn1_mask", mem_wmask, 32'h0000_FFFF);
    check_eq("drn1_data", mem_wdata, 32'h0102_0304);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("drn2_mask", mem_wmask, 32'hFF00_0000);
    check_eq("drn2_addr", mem_addr, 10'h51);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("drn_empty", ifc.wbuf_empty, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("drn_we_count", we_cnt - we_base, 2);
    check_eq("drn_macro50", mem_model[10'h50], 32'h0000_0304);
    check_eq("drn_macro51", mem_model[10'h51], 32'hA000_0000);

    // Reset mid-burst discards pending writes
    cyc(1'b1, 10'h60, 32'h1111_1111, 4'hF, 1'b1, 10'h7);
    cyc(1'b1, 10'h61, 32'h2222_2222, 4'hF, 1'b1, 10'h7);
    check_eq("mid_r_data", ifc.r_data, 32'h7777_7777);
    @(negedge clk);
    rst_n = 1'b0;
    ifc.w_valid = 1'b0; ifc.r_valid = 1'b0;
    #1;
    check_eq("mid_rst_w_ready", ifc.w_ready, 1'b1);
    check_eq("mid_rst_empty", ifc.wbuf_empty, 1'b1);
    check_eq("mid_rst_rdv", ifc.r_data_valid, 1'b0);
    check_eq("mid_rst_r_data", ifc.r_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_we", mem_we, 1'b0);
    check_eq("post_rst_ce", mem_ce, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq("post_rst_macro60", mem_model[10'h60], 32'h0);
    check_eq("post_rst_macro61", mem_model[10'h61], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
